// File: rtl/cordic_out_stage.sv
// Output stage of the pipelined CORDIC: merges coarse/residual pairs, rounds and
// saturates, applies the octant fold, and buffers results behind valid/ready.
module cordic_out_stage #(
  parameter int FIFO_DEPTH = 4,
  parameter int OUT_W      = 16,
  parameter int FRAC_SHIFT = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wen_in,
  input  logic [9:0]                    index_cor,
  input  logic [15:0]                   XM_,
  input  logic [15:0]                   YM_,
  input  logic [15:0]                   XR_,
  input  logic [15:0]                   YR_,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [OUT_W-1:0]              cos_out,
  output logic [OUT_W-1:0]              sin_out,
  output logic [6:0]                    out_index,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = 16 + FRAC_SHIFT + 1;
  localparam int RW = (CW + 1 > OUT_W + 1) ? CW + 1 : OUT_W + 1;

  localparam logic signed [OUT_W-1:0] OMAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] OMIN = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic signed [RW-1:0]    RMAX = {{(RW-OUT_W){1'b0}}, OMAX};
  localparam logic signed [RW-1:0]    RMIN = {{(RW-OUT_W){1'b1}}, OMIN};
  localparam logic [AW:0]             DEPTH_L = (AW+1)'(FIFO_DEPTH);

  // Adding half an LSB before the arithmetic shift is the same as adding bit
  // [FRAC_SHIFT-1] to the truncated value; the extra headroom makes the clamp exact.
  function automatic logic signed [OUT_W-1:0] merge_round(input logic [15:0] m,
                                                          input logic [15:0] r);
    logic signed [RW-1:0] wide;
    logic signed [RW-1:0] rnd;
    wide = (RW'($signed(m)) <<< FRAC_SHIFT) + RW'($signed(r))
         + (RW'(1) <<< (FRAC_SHIFT - 1));
    rnd  = wide >>> FRAC_SHIFT;
    if (rnd > RMAX)      return OMAX;
    else if (rnd < RMIN) return OMIN;
    else                 return rnd[OUT_W-1:0];
  endfunction

  function automatic logic signed [OUT_W-1:0] neg_sat(input logic signed [OUT_W-1:0] v);
    return (v == OMIN) ? OMAX : -v;
  endfunction

  logic                    v1;
  logic signed [OUT_W-1:0] c1;
  logic signed [OUT_W-1:0] s1;
  logic [2:0]              oct1;
  logic [6:0]              idx1;

  always_ff @(posedge clk) begin
    if (reset) begin
      v1   <= 1'b0;
      c1   <= '0;
      s1   <= '0;
      oct1 <= '0;
      idx1 <= '0;
    end else begin
      v1 <= wen_in;
      if (wen_in) begin
        c1   <= merge_round(XM_, XR_);
        s1   <= merge_round(YM_, YR_);
        oct1 <= index_cor[9:7];
        idx1 <= index_cor[6:0];
      end
    end
  end

  logic signed [OUT_W-1:0] neg_c;
  logic signed [OUT_W-1:0] neg_s;
  logic signed [OUT_W-1:0] fold_cos;
  logic signed [OUT_W-1:0] fold_sin;

  assign neg_c = neg_sat(c1);
  assign neg_s = neg_sat(s1);

  always_comb begin
    fold_cos = c1;
    fold_sin = s1;
    case (oct1)
      3'd0: begin fold_cos = c1;    fold_sin = s1;    end
      3'd1: begin fold_cos = s1;    fold_sin = c1;    end
      3'd2: begin fold_cos = neg_s; fold_sin = c1;    end
      3'd3: begin fold_cos = neg_c; fold_sin = s1;    end
      3'd4: begin fold_cos = neg_c; fold_sin = neg_s; end
      3'd5: begin fold_cos = neg_s; fold_sin = neg_c; end
      3'd6: begin fold_cos = s1;    fold_sin = neg_c; end
      default: begin fold_cos = c1; fold_sin = neg_s; end
    endcase
  end

  logic             v2;
  logic [OUT_W-1:0] cos2;
  logic [OUT_W-1:0] sin2;
  logic [6:0]       idx2;

  always_ff @(posedge clk) begin
    if (reset) begin
      v2   <= 1'b0;
      cos2 <= '0;
      sin2 <= '0;
      idx2 <= '0;
    end else begin
      v2 <= v1;
      if (v1) begin
        cos2 <= fold_cos;
        sin2 <= fold_sin;
        idx2 <= idx1;
      end
    end
  end

  // The pipeline cannot stall, so a push into a full FIFO without a pop is dropped.
  logic [OUT_W-1:0] mem_cos [FIFO_DEPTH];
  logic [OUT_W-1:0] mem_sin [FIFO_DEPTH];
  logic [6:0]       mem_idx [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      level;
  logic             full;
  logic             pop;
  logic             accept;

  assign full   = (level == DEPTH_L);
  assign pop    = out_valid && out_ready;
  assign accept = v2 && (!full || pop);

  always_ff @(posedge clk) begin
    if (!reset && accept) begin
      mem_cos[wr_ptr] <= cos2;
      mem_sin[wr_ptr] <= sin2;
      mem_idx[wr_ptr] <= idx2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + AW'(1);
      if (pop)    rd_ptr <= rd_ptr + AW'(1);
      case ({accept, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
      if (v2 && full && !pop) overflow <= 1'b1;
    end
  end

  assign out_valid  = (level != '0);
  assign fifo_level = level;
  assign cos_out    = out_valid ? mem_cos[rd_ptr] : '0;
  assign sin_out    = out_valid ? mem_sin[rd_ptr] : '0;
  assign out_index  = out_valid ? mem_idx[rd_ptr] : '0;

endmodule

// File: doc/cordic_out_stage.md
Name: cordic_out_stage

Overview:
- Final stage of the pipelined CORDIC datapath, directly downstream of the last cordic cell/buffer stage.
- Merges each coarse/residual pair (XM/XR, YM/YR) into one rounded, saturated OUT_W-bit value.
- Applies the 3-bit octant fold carried in index_cor[9:7] to produce cos/sin.
- Results are queued in a small FIFO behind a valid/ready interface, because the CORDIC pipeline cannot stall.

Parameters:
- FIFO_DEPTH, 4, output FIFO entries; power of two, at least 2.
- OUT_W, 16, output sample width, two's complement.
- FRAC_SHIFT, 8, weight of XM/YM relative to XR/YR; combined width = 16+FRAC_SHIFT.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- wen_in  in  1  sample valid from last cordic stage
- index_cor  in  10  [9:7] octant, [6:0] sample index
- XM_  in  16  coarse X, signed
- YM_  in  16  coarse Y, signed
- XR_  in  16  residual X, signed
- YR_  in  16  residual Y, signed
- out_ready  in  1  consumer accepts head sample
- out_valid  out  1  FIFO head valid
- cos_out  out  OUT_W  cosine, signed
- sin_out  out  OUT_W  sine, signed
- out_index  out  7  index_cor[6:0] of head sample
- fifo_level  out  clog2(FIFO_DEPTH)+1  occupied entries
- overflow  out  1  sticky: a sample was dropped

Behaviour:
- One clock; reset is synchronous and active-high.
- On reset, every pipeline register, the FIFO pointers and the flags clear:
  - out_valid=0, cos_out=0, sin_out=0, out_index=0, fifo_level=0, overflow=0.
  - Samples in flight are discarded.
- The entire datapath, including wen_in, is gated by reset.

- Stage 1 (registered, captured when wen_in=1):
  - X = (sext(XM_) << FRAC_SHIFT) + sext(XR_), computed at 16+FRAC_SHIFT+1 bits.
  - Y is formed the same way from YM_/YR_.
  - Round half-up: take bits [FRAC_SHIFT+OUT_W-1 : FRAC_SHIFT] and add bit [FRAC_SHIFT-1].
  - Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1], giving c, s.
  - Valid bit v1 = wen_in. Octant and index are delayed alongside.

- Stage 2 (registered), octant o maps to (cos, sin):
  - 0: (c, s)
  - 1: (s, c)
  - 2: (-s, c)
  - 3: (-c, s)
  - 4: (-c, -s)
  - 5: (-s, -c)
  - 6: (s, -c)
  - 7: (c, -s)
  - Negation saturates: -(-2^(OUT_W-1)) = 2^(OUT_W-1)-1.
  - v2 = v1.

- FIFO write and read:
  - v2=1 pushes {cos, sin, index} on that edge.
  - A pop happens on an edge where out_valid && out_ready.
  - The outputs show the FIFO head; out_valid = (level != 0). Outputs are held stable while out_valid && !out_ready.
  - Latency: a sample on wen_in at edge N is stage-1 at N, stage-2 at N+1, written at N+2. out_valid is visible after N+2 when the FIFO was empty, so it is sampleable by the consumer at edge N+3.
  - Throughput is one sample per clock, back to back.

- Boundary conditions:
  - Full (level = FIFO_DEPTH), push without a simultaneous pop: the new sample is dropped, overflow is set and stays 1 until reset, and the stored contents and order are unchanged.
  - Full with simultaneous push and pop: both happen, level stays FIFO_DEPTH, no overflow.
  - Empty with push: out_valid rises on the next cycle. The FIFO has no fall-through, so out_ready while empty has no effect.
  - Pointers wrap modulo FIFO_DEPTH.
  - fifo_level never exceeds FIFO_DEPTH.
  - Reset asserted mid-stream: all state clears on that edge, and samples in stages 1–2 are lost.
  - Reset has priority over push and pop.

Test Plan:
1. Basic merge and latency:
   - Stimulus: octant 0, XM_=16'h4000, XR_=16'h0080, YM_=YR_=0, wen_in pulse at edge N, out_ready=1.
   - Required: out_valid seen at N+3 with cos_out=16'h4001, sin_out=16'h0000, out_index matching the input. fifo_level returns to 0 after the pop.
2. Octant sweep:
   - Stimulus: same data as scenario 1 (c=16'h4001, s=0), octants 0–7 on consecutive cycles.
   - Required: (cos, sin) = (4001,0), (0,4001), (0,4001), (BFFF,0), (BFFF,0), (0,BFFF), (0,BFFF), (4001,0), in order, with no gaps.
3. Saturation:
   - Case A: XM_=16'h7FFF, XR_=16'h0080, octant 0. Required: cos_out=16'h7FFF.
   - Case B: XM_=16'h8000, XR_=0, octant 3. Required: cos_out=16'h7FFF, i.e. the negation saturates.
4. Backpressure and overflow:
   - Stimulus: out_ready=0, 6 consecutive samples with index 1–6.
   - Required: fifo_level=4, overflow=1, and the head is index 1.
   - Then raise out_ready. Required: indices 1, 2, 3, 4 are delivered, out_valid falls, and overflow stays 1.
5. Full with simultaneous push/pop:
   - Stimulus: FIFO full, out_ready=1, a continuous stream on wen_in.
   - Required: fifo_level stays 4, overflow stays 0, and indices emerge strictly in order.
6. Reset mid-stream:
   - Stimulus: assert reset while 2 samples are in flight and 3 are queued.
   - Required: on the next cycle out_valid=0, fifo_level=0, overflow=0, and no stale sample appears after reset deasserts.
